mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Multi-cycle RV64 M-extension execution unit.
- Consumes the 5-bit ALU control code produced by the ALU decoder for M-type and M-type-W instructions.
- Takes two 64-bit operands and returns a 64-bit result with a start/busy/done handshake.
- Sits beside the single-cycle ALU in the execute stage; the pipeline stalls on busy_o.

Parameters:
XLEN, 64, operand/result width; only 64 supported.
CNT_W, 7, iteration-counter width (covers 64 iterations).

Ports:
clk_i  input  1  clock, rising edge.
arstn_i  input  1  asynchronous active-low reset.
start_i  input  1  request valid; sampled only when busy_o=0.
flush_i  input  1  abort the in-flight operation; priority over start_i.
alu_control_i  input  5  operation code (M range 01111..11011).
src_1_i  input  64  dividend / multiplicand (rs1).
src_2_i  input  64  divisor / multiplier (rs2).
busy_o  input→output  1  high while the operation is in flight.
done_o  output  1  one-cycle pulse; result_o valid.
result_o  output  64  result; held from the done_o cycle until the next accept.

Behaviour:
- Reset (arstn_i=0, async): state=IDLE, busy_o=0, done_o=0, result_o=0, counter=0, internal operand regs=0.
- Accept: start_i=1 with state IDLE or DONE and code in M range → latch op, operands, signs, W flag. Codes outside 01111..11011 are ignored: no state change, no done_o.
- States:
  - IDLE: idle.
  - MUL: busy, 1 cycle.
  - DIV: busy, iterating.
  - DONE: done_o=1 for exactly 1 cycle, then IDLE unless a new accept occurs.
- MUL, MULH, MULHSU, MULHU, MULW (accept in cycle N):
  - Cycle N+1: 128-bit product registered.
  - done_o in cycle N+2.
  - Result selection: MUL = prod[63:0]; MULH/MULHSU/MULHU = prod[127:64] with signed×signed, signed×unsigned, unsigned×unsigned operands respectively; MULW = sign-extend(prod[31:0]) of the low-32-bit operands.
- DIV, DIVU, REM, REMU: radix-2 restoring division on magnitudes.
  - 64 iterations in cycles N+1..N+64; done_o in cycle N+65.
  - Signed ops negate a negative quotient when sign(a)≠sign(b); the remainder takes sign(a).
- DIVW, DIVUW, REMW, REMUW:
  - Operands are the low 32 bits, sign- or zero-extended per op.
  - 32 iterations; done_o in cycle N+33.
  - Result is the 32-bit quotient/remainder sign-extended to 64 bits (also for the unsigned W ops).
- Special cases are detected at accept, skip DIV, and give done_o in cycle N+1:
  - Divide by zero: quotient = all ones (W: sign-ext 32'hFFFFFFFF); remainder = dividend (W: sign-ext low 32).
  - Signed overflow (most-negative ÷ -1, 64- or 32-bit per W): quotient = dividend; remainder = 0.
- busy_o = (state==MUL || state==DIV). An accept in DONE is legal: done_o stays 1 that cycle and the next state follows the new op.
- flush_i=1 in any state: next state IDLE, done_o=0 next cycle, result_o unchanged, start_i ignored that cycle.
- An async reset mid-operation returns the unit to the reset values immediately; no done_o is produced.
- Operand inputs are don't-care after the accept cycle.

Decomposition:
- Shared package mdu_pkg:
  - 5-bit localparams for each code: MUL=01111, MULH=10000, MULHSU=10001, MULHU=10010, DIV=10011, DIVU=10100, REM=10101, REMU=10110, MULW=10111, DIVW=11000, DIVUW=11001, REMW=11010, REMUW=11011.
  - State enum typedef.
  - These codes are shared with alu_decoder.
- One sub-module: div_core.
  - Iterative restoring divider on unsigned magnitudes.
  - Interface: start, width select (32/64), done, quotient, remainder.
- Sign handling, the special-case bypass and the multiplier stay in mul_div_unit.

Test Plan:
- MUL 7×(-3) (src_2=64'hFFFF_FFFF_FFFF_FFFD), start in cycle 0 → done_o cycle 2, result 64'hFFFF_FFFF_FFFF_FFEB; busy_o=1 in cycle 1 only.
- MULHU all-ones × all-ones → result 64'hFFFF_FFFF_FFFF_FFFE. MULH of the same operands → 0. MULHSU(-1, 2) → 64'hFFFF_FFFF_FFFF_FFFF.
- DIV -20 ÷ 6 → done_o exactly cycle 65, result 64'hFFFF_FFFF_FFFF_FFFD. REM with the same operands → 64'hFFFF_FFFF_FFFF_FFFE.
- DIVUW src_1=64'h0000_0000_8000_0000, src_2=2 → done_o cycle 33, result 64'h0000_0000_4000_0000. REMW 32'h8000_0000 ÷ -1 → 0, done_o cycle 1.
- DIVU x÷0 → all ones in cycle 1. REM 13÷0 → 13. DIV 64'h8000_0000_0000_0000 ÷ -1 → 64'h8000_0000_0000_0000.
- Flush and reset:
  - flush_i at cycle 20 of a DIV → no done_o, busy_o=0 in cycle 21; a new MUL accepted in cycle 21 completes in cycle 23.
  - arstn_i pulsed low mid-DIV → all outputs are 0 immediately.
  - start_i with code 00000 → ignored.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension execution unit: ALU control
// codes (common with alu_decoder), FSM state type and small helpers.
package mdu_pkg;

    localparam logic [4:0] MUL    = 5'b01111;
    localparam logic [4:0] MULH   = 5'b10000;
    localparam logic [4:0] MULHSU = 5'b10001;
    localparam logic [4:0] MULHU  = 5'b10010;
    localparam logic [4:0] DIV    = 5'b10011;
    localparam logic [4:0] DIVU   = 5'b10100;
    localparam logic [4:0] REM    = 5'b10101;
    localparam logic [4:0] REMU   = 5'b10110;
    localparam logic [4:0] MULW   = 5'b10111;
    localparam logic [4:0] DIVW   = 5'b11000;
    localparam logic [4:0] DIVUW  = 5'b11001;
    localparam logic [4:0] REMW   = 5'b11010;
    localparam logic [4:0] REMUW  = 5'b11011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // True for every code this unit executes.
    function automatic logic is_m_op(input logic [4:0] code);
        return (code >= MUL) && (code <= REMUW);
    endfunction

    // Sign-extend a 32-bit word result to 64 bits.
    function automatic logic [63:0] sext_w(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle: 64 iterations, or 32 in word mode.
// quotient_o/remainder_o carry the post-iteration values and are
// final in the cycle done_o is high.
module div_core
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(XLEN / 2 - 1);

    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             word_q, word_d;

    logic [XLEN:0]    rem_shift;
    logic             ge;
    logic [XLEN-1:0]  step_quo;
    logic [XLEN-1:0]  step_rem;

    // One restoring step plus load/abort control.
    always_comb begin
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        word_d   = word_q;

        // rem_shift is one bit wider so a divisor with bit 63 set still
        // compares correctly; the wrapped 64-bit difference is exact when ge.
        rem_shift = {rem_q, quo_q[XLEN-1]};
        ge        = rem_shift >= {1'b0, dvs_q};
        step_quo  = {quo_q[XLEN-2:0], ge};
        step_rem  = ge ? (rem_shift[XLEN-1:0] - dvs_q) : rem_shift[XLEN-1:0];

        done_o      = active_q && (cnt_q == (word_q ? LAST_W : LAST_D));
        quotient_o  = step_quo;
        remainder_o = step_rem;

        if (kill_i) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start_i) begin
            // Word mode parks the 32-bit dividend in the upper half so the
            // same MSB-first shift consumes it in 32 steps.
            quo_d    = word_i ? {dividend_i[XLEN/2-1:0], {(XLEN/2){1'b0}}} : dividend_i;
            rem_d    = '0;
            dvs_d    = divisor_i;
            cnt_d    = '0;
            active_d = 1'b1;
            word_d   = word_i;
        end else if (active_q) begin
            quo_d = step_quo;
            rem_d = step_rem;
            if (done_o) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            word_q   <= 1'b0;
        end else begin
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            word_q   <= word_d;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// RV64 M-extension execution unit: single-cycle registered multiplier,
// iterative divider (div_core), sign handling and special-case bypass,
// behind a start/busy/done handshake.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [4:0]      alu_control_i,
    input  logic [XLEN-1:0] src_1_i,
    input  logic [XLEN-1:0] src_2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    mdu_state_e      state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            w_q, w_d;
    logic [XLEN-1:0] result_q, result_d;

    // Incoming-op decode and operand preparation
    logic            in_w, in_mul, in_signed, in_rem;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val;
    logic            a_neg, b_neg, div_zero, overflow, accept;
    logic [XLEN-1:0] special_raw, special_res;

    // Multiplier and divider result paths
    logic [2*XLEN-1:0] prod_u;
    logic [XLEN-1:0]   hi_su, hi_ss, mul_res;
    logic [XLEN-1:0]   quo_s, rem_s, div_raw, div_res;
    logic              op_is_rem;

    logic            div_start;
    logic            div_done;
    logic [XLEN-1:0] div_quo, div_rem;

    // Decode the requested op and precompute magnitudes and special results.
    always_comb begin
        in_w      = alu_control_i >= MULW;
        in_mul    = (alu_control_i <= MULHU) || (alu_control_i == MULW);
        in_signed = (alu_control_i == DIV)  || (alu_control_i == REM) ||
                    (alu_control_i == DIVW) || (alu_control_i == REMW);
        in_rem    = (alu_control_i == REM)  || (alu_control_i == REMU) ||
                    (alu_control_i == REMW) || (alu_control_i == REMUW);

        a_ext = in_w ? (in_signed ? sext_w(src_1_i[31:0]) : {32'b0, src_1_i[31:0]}) : src_1_i;
        b_ext = in_w ? (in_signed ? sext_w(src_2_i[31:0]) : {32'b0, src_2_i[31:0]}) : src_2_i;

        a_neg = in_signed && a_ext[XLEN-1];
        b_neg = in_signed && b_ext[XLEN-1];
        mag_a = a_neg ? (-a_ext) : a_ext;
        mag_b = b_neg ? (-b_ext) : b_ext;

        min_val  = in_w ? {32'hFFFF_FFFF, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        overflow = in_signed && (a_ext == min_val) && (b_ext == '1);

        if (div_zero) begin
            special_raw = in_rem ? a_ext : '1;
        end else begin
            special_raw = in_rem ? '0 : a_ext;
        end
        special_res = in_w ? sext_w(special_raw[31:0]) : special_raw;

        accept = start_i && !flush_i && is_m_op(alu_control_i) &&
                 ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    // Product of the latched operands with high-half sign correction:
    // signed(x) = x - x[63]*2^64, so each signed operand subtracts the
    // other operand from the unsigned high half.
    always_comb begin
        prod_u = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
        hi_su  = prod_u[2*XLEN-1:XLEN] - (a_q[XLEN-1] ? b_q : '0);
        hi_ss  = hi_su - (b_q[XLEN-1] ? a_q : '0);
        case (op_q)
            MULH:    mul_res = hi_ss;
            MULHSU:  mul_res = hi_su;
            MULHU:   mul_res = prod_u[2*XLEN-1:XLEN];
            MULW:    mul_res = sext_w(prod_u[31:0]);
            default: mul_res = prod_u[XLEN-1:0];
        endcase
    end

    // Restore signs on the divider magnitudes and select quotient/remainder.
    always_comb begin
        op_is_rem = (op_q == REM) || (op_q == REMU) || (op_q == REMW) || (op_q == REMUW);
        quo_s     = qneg_q ? (-div_quo) : div_quo;
        rem_s     = rneg_q ? (-div_rem) : div_rem;
        div_raw   = op_is_rem ? rem_s : quo_s;
        div_res   = w_q ? sext_w(div_raw[31:0]) : div_raw;
    end

    // Next-state, operand latch and result capture.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        w_d       = w_q;
        result_d  = result_q;
        div_start = 1'b0;

        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_MUL: begin
                    state_d  = ST_DONE;
                    result_d = mul_res;
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_d  = ST_DONE;
                        result_d = div_res;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    if (accept) begin
                        op_d   = alu_control_i;
                        a_d    = src_1_i;
                        b_d    = src_2_i;
                        qneg_d = a_neg ^ b_neg;
                        rneg_d = a_neg;
                        w_d    = in_w;
                        if (in_mul) begin
                            state_d = ST_MUL;
                        end else if (div_zero || overflow) begin
                            state_d  = ST_DONE;
                            result_d = special_res;
                        end else begin
                            state_d   = ST_DIV;
                            div_start = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            w_q      <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            w_q      <= w_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

    div_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div_core (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .start_i     (div_start),
        .kill_i      (flush_i),
        .word_i      (in_w),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

endmodule
